// File: rtl/press_counter.sv
// press_counter
// Counts debounced push-button presses during a round and presents the
// running total to the answer-period stage.
//
// Ports:
//   Clk100M    in  : system clock, all logic on the rising edge
//   ResetN     in  : synchronous, active-low reset
//   buttonIn   in  : raw asynchronous bouncing button level, active high
//   roundStart in  : one-cycle pulse, clears the count and starts counting
//   stopCount  in  : one-cycle pulse, freezes the count
//   userCount  out : running press total, saturates at MAX_COUNT
//   counting   out : high while presses are being accepted
//   pressPulse out : one-cycle strobe per accepted debounced rising edge
//   overflow   out : sticky, a press arrived while already at MAX_COUNT
module press_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned MAX_COUNT       = 99
) (
    input  logic       Clk100M,
    input  logic       ResetN,
    input  logic       buttonIn,
    input  logic       roundStart,
    input  logic       stopCount,
    output logic [6:0] userCount,
    output logic       counting,
    output logic       pressPulse,
    output logic       overflow
);

    localparam int unsigned    DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]      MAX_Q   = 7'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            deb_prev_q, deb_prev_d;
    logic            press_pulse_q, press_pulse_d;
    state_e          state_q, state_d;
    logic [6:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            rise;

    // Synchroniser, debouncer and edge detect.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s1_d       = buttonIn;
        s2_d       = s1_q;
        deb_d      = deb_q;
        db_cnt_d   = '0;
        deb_prev_d = deb_q;

        // The counter only runs while the synchronised level disagrees with
        // the accepted level; any return to the accepted level restarts it.
        if (s2_q != deb_q) begin
            if (db_cnt_q == DB_LAST) begin
                deb_d    = s2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

        rise          = deb_q & ~deb_prev_q;
        press_pulse_d = rise;
    end

    // Round FSM and press counter. Priority: roundStart, then stopCount,
    // then a press, so a coincident press is never counted.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (roundStart) begin
                    state_d    = COUNTING;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            COUNTING: begin
                if (roundStart) begin
                    count_d = '0;
                end else if (stopCount) begin
                    state_d = LOCKED;
                end else if (rise) begin
                    if (count_q == MAX_Q) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + 7'd1;
                    end
                end
            end
            LOCKED: begin
                if (roundStart) begin
                    state_d = COUNTING;
                    count_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk100M) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!ResetN) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            deb_q         <= 1'b0;
            db_cnt_q      <= '0;
            deb_prev_q    <= 1'b0;
            press_pulse_q <= 1'b0;
            state_q       <= IDLE;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            deb_q         <= deb_d;
            db_cnt_q      <= db_cnt_d;
            deb_prev_q    <= deb_prev_d;
            press_pulse_q <= press_pulse_d;
            state_q       <= state_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign userCount  = count_q;
    assign counting   = (state_q == COUNTING);
    assign pressPulse = press_pulse_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/press_counter.md
# press_counter

Counts the player's debounced button presses during a round and presents the running total as `userCount` to the answer-period stage, which displays it and ends the round. Sits between the raw push-button pin and the answer-period stage. Counting starts on `roundStart` and is frozen by the answer-period stage's `stopCount` pulse. Single 100 MHz domain; the raw button input is synchronised internally.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive cycles a changed synchronised level must persist before it is accepted (10 ms at 100 MHz). Legal range is 1 or more.
- `MAX_COUNT`, default 99: saturation value of `userCount`. Legal range is 1..127.
- `Clk100M` in 1: system clock. All logic is on its rising edge.
- `ResetN` in 1: synchronous, active-low reset.
- `buttonIn` in 1: raw, asynchronous, bouncing push-button level, active high.
- `roundStart` in 1: one-cycle pulse. Clears the count and starts counting.
- `stopCount` in 1: one-cycle pulse from the answer-period stage. Freezes the count.
- `userCount` out 7: running press total, unsigned, range 0..`MAX_COUNT`.
- `counting` out 1: high while presses are being accepted.
- `pressPulse` out 1: one-cycle strobe for every accepted debounced rising edge, in any state.
- `overflow` out 1: sticky flag. Set when a press arrives while the count is already `MAX_COUNT`.

## Operation
- **Synchroniser:** two flops, `buttonIn` to `s1` to `s2`. Reset value 0.
- **Debouncer:** registers `deb` (reset 0) and `dbCnt` (reset 0, width ceil(log2(`DEBOUNCE_CYCLES`+1))).
  - If `s2` equals `deb`, `dbCnt` is set to 0.
  - Otherwise `dbCnt` increments. When `dbCnt` equals `DEBOUNCE_CYCLES`-1, `deb` is set to `s2` and `dbCnt` is set to 0.
  - Any bounce back to the `deb` level restarts the count.
- **Edge detect:** `debPrev` is registered from `deb`. `rise` is `deb & ~debPrev`. `pressPulse` is registered from `rise`.
- **FSM states:** `IDLE` (reset state), `COUNTING`, `LOCKED`.
  - `IDLE`: `roundStart` goes to `COUNTING` and clears `userCount` and `overflow`. Presses are ignored.
  - `COUNTING`: `rise` increments `userCount`, saturating at `MAX_COUNT`. A `rise` at `MAX_COUNT` sets `overflow` and leaves the count unchanged. `stopCount` goes to `LOCKED` and holds `userCount`. `roundStart` stays in `COUNTING` and clears the count.
  - `LOCKED`: `userCount` and `overflow` are held. Presses are ignored. `roundStart` goes to `COUNTING` and clears the count.
- **Simultaneous events:**
  - `roundStart` together with `stopCount`: `roundStart` wins. Next state is `COUNTING` with count 0.
  - `rise` together with `roundStart`: the press is not counted. Count is 0.
  - `rise` together with `stopCount` in `COUNTING`: the press is not counted. Go to `LOCKED`.
- **Outputs:** `counting` is 1 only in `COUNTING`.
- **Reset values:** `userCount` = 0, `counting` = 0, `pressPulse` = 0, `overflow` = 0. State is `IDLE`, and all internal registers are 0.
- **Reset mid-operation:** `ResetN` low on any edge returns every register to its reset value, including mid-debounce.

## Timing
- **Input to accepted level:** with `buttonIn` stable-high from edge t, `s2` is high at t+2 and `deb` is high at t+1+`DEBOUNCE_CYCLES`.
- **Press outputs:** `pressPulse` is high for exactly 1 cycle, at t+2+`DEBOUNCE_CYCLES`.
- **Count update:** `userCount` shows the new value in the same cycle as `pressPulse`.
- **Control inputs:** `roundStart` and `stopCount` take effect on the next edge. `counting` and `userCount` reflect them one cycle after the pulse.
- **Release:** a release also needs `DEBOUNCE_CYCLES` stable cycles, but produces no pulse.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` cycles produces no change on `deb`.
- **Throughput:** at most one count per debounced press.

## Test plan
- **Debounce basic:** `DEBOUNCE_CYCLES`=4, `roundStart`, hold `buttonIn` high from t -> `pressPulse` high only at t+6, `userCount`=1.
- **Bounce rejection:** toggle `buttonIn` every 2 cycles for 20 cycles, then hold high -> exactly one `pressPulse`, `userCount`=1.
- **Saturation:** `MAX_COUNT`=99, 101 clean presses while `COUNTING` -> `userCount`=99, `overflow`=1 after press 100, 101 `pressPulse` strobes.
- **Freeze and ignore:** 5 presses, `stopCount`, 3 more presses -> `userCount`=5, `counting`=0, 3 `pressPulse` strobes still seen. Then `roundStart` -> `userCount`=0, `counting`=1.
- **Simultaneous events:** `roundStart` and `stopCount` in the same cycle -> `COUNTING`, count 0. `rise` coincident with `stopCount` at count 7 -> `LOCKED`, count 7.
- **Reset mid-debounce:** `ResetN` low 2 cycles into a debounce window at count 3 -> all outputs 0, `IDLE`, no `pressPulse` afterwards until a fresh stable press.
